// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light controller slice: lane filter
// state codes, light codes and the lane counter sizing helpers.
package tl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARRIVE  = 3'd1,
        S_PRESENT = 3'd2,
        S_LEAVE   = 3'd3,
        S_STUCK   = 3'd4
    } lane_state_e;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_e;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

    // Wide enough that every lane count stops at its compare value before wrapping.
    function automatic int lane_cnt_width(input int db, input int hold, input int stuck);
        return $clog2(max_of3(db, hold, stuck) + 32'sd1);
    endfunction

endpackage

// File: rtl/tl_sensor_cond_if.sv
// Detector pins in, conditioned traffic/fault flags out.
interface tl_sensor_cond_if;

    logic raw_a;
    logic raw_b;
    logic Ta;
    logic Tb;
    logic stuck_a;
    logic stuck_b;

    modport master (
        output raw_a,
        output raw_b,
        input  Ta,
        input  Tb,
        input  stuck_a,
        input  stuck_b
    );

    modport slave (
        input  raw_a,
        input  raw_b,
        output Ta,
        output Tb,
        output stuck_a,
        output stuck_b
    );

endinterface

// File: rtl/tl_lane_filter.sv
// One detector lane: 2-flop synchronizer, debounce / gap-extend / stuck FSM
// and its shared counter. Outputs are registered copies of the next-state decode.
module tl_lane_filter
    import tl_pkg::*;
#(
    parameter int DB_CYC    = 16,
    parameter int HOLD_CYC  = 256,
    parameter int STUCK_CYC = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic present,
    output logic stuck
);

    localparam int CW = lane_cnt_width(DB_CYC, HOLD_CYC, STUCK_CYC);

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(32'sd1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYC - 32'sd1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 32'sd1);
    localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYC - 32'sd1);

    logic        sync1_r;
    logic        sync2_r;
    logic        s_s;
    lane_state_e state_r;
    lane_state_e state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic        present_r;
    logic        stuck_r;

    // Two-flop synchronizer for the asynchronous detector pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    assign s_s = sync2_r;

    // Lane state and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter update; every exit from a state clears the counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (s_s) begin
                    if (DB_CYC == 32'sd1) begin
                        state_nxt_s = S_PRESENT;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = S_ARRIVE;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            S_ARRIVE: begin
                if (!s_s) begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == DB_LAST) begin
                    state_nxt_s = S_PRESENT;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = S_ARRIVE;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            S_PRESENT: begin
                if (!s_s) begin
                    if (HOLD_CYC == 32'sd1) begin
                        state_nxt_s = S_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = S_LEAVE;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else if (cnt_r == STUCK_LAST) begin
                    state_nxt_s = S_STUCK;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = S_PRESENT;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            S_LEAVE: begin
                // A car reappearing inside the gap restarts the presence age.
                if (s_s) begin
                    state_nxt_s = S_PRESENT;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == HOLD_LAST) begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = S_LEAVE;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            S_STUCK: begin
                if (!s_s) begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = S_STUCK;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output flops track the decode of the next state, so they change on the
    // same edge as the state register but cannot glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            present_r <= 1'b0;
            stuck_r   <= 1'b0;
        end else begin
            present_r <= (state_nxt_s == S_PRESENT) || (state_nxt_s == S_LEAVE);
            stuck_r   <= (state_nxt_s == S_STUCK);
        end
    end

    assign present = present_r;
    assign stuck   = stuck_r;

endmodule

// File: rtl/tl_sensor_cond.sv
// Car-detector front end: two independent lane filters producing the
// Ta/Tb traffic-present inputs and stuck-detector flags for the controller.
module tl_sensor_cond #(
    parameter int DB_CYC    = 16,
    parameter int HOLD_CYC  = 256,
    parameter int STUCK_CYC = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    tl_sensor_cond_if.slave  bus
);

    tl_lane_filter #(
        .DB_CYC    (DB_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .STUCK_CYC (STUCK_CYC)
    ) U0 (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (bus.raw_a),
        .present (bus.Ta),
        .stuck   (bus.stuck_a)
    );

    tl_lane_filter #(
        .DB_CYC    (DB_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .STUCK_CYC (STUCK_CYC)
    ) U1 (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (bus.raw_b),
        .present (bus.Tb),
        .stuck   (bus.stuck_b)
    );

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Self-checking bench for tl_sensor_cond: directed and random detector
// waveforms compared every cycle against a run-length reference model.
module tb_tl_sensor_cond;

    localparam int DB    = 4;
    localparam int HOLD  = 8;
    localparam int STUCK = 64;

    logic clk = 1'b0;
    logic reset_n;

    tl_sensor_cond_if bus();

    tl_sensor_cond #(
        .DB_CYC    (DB),
        .HOLD_CYC  (HOLD),
        .STUCK_CYC (STUCK)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0b exp=%0b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: pin delayed two samples, then judged by run lengths of the
    // sampled level and the age of the current presence episode.
    bit m_s1[2];
    bit m_s2[2];
    bit m_pres[2];
    bit m_stuck[2];
    int hi_run[2];
    int lo_run[2];
    int age[2];

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            m_s1[l] = 1'b0; m_s2[l] = 1'b0;
            m_pres[l] = 1'b0; m_stuck[l] = 1'b0;
            hi_run[l] = 0; lo_run[l] = 0; age[l] = 0;
        end
    endtask

    task automatic model_edge(input int l, input bit raw);
        bit s;
        s = m_s2[l];
        m_s2[l] = m_s1[l];
        m_s1[l] = raw;
        if (m_stuck[l]) begin
            if (!s) m_stuck[l] = 1'b0;
        end else if (m_pres[l]) begin
            if (!s) begin
                if (lo_run[l] + 1 >= HOLD) m_pres[l] = 1'b0;
            end else begin
                if (lo_run[l] > 0) age[l] = 0;
                else               age[l] = age[l] + 1;
                if (age[l] >= STUCK) begin
                    m_stuck[l] = 1'b1;
                    m_pres[l]  = 1'b0;
                end
            end
        end else if (s && (hi_run[l] + 1 >= DB)) begin
            m_pres[l] = 1'b1;
            age[l]    = 0;
        end
        if (s) begin hi_run[l]++; lo_run[l] = 0; end
        else   begin lo_run[l]++; hi_run[l] = 0; end
    endtask

    // One clock: drive pins, let the edge happen, check on the falling edge.
    task automatic cycle(input bit ra, input bit rb);
        bus.raw_a = ra;
        bus.raw_b = rb;
        @(posedge clk);
        model_edge(0, ra);
        model_edge(1, rb);
        @(negedge clk);
        chk("Ta",      bus.Ta,      m_pres[0]);
        chk("Tb",      bus.Tb,      m_pres[1]);
        chk("stuck_a", bus.stuck_a, m_stuck[0]);
        chk("stuck_b", bus.stuck_b, m_stuck[1]);
    endtask

    task automatic run(input bit ra, input bit rb, input int n);
        for (int i = 0; i < n; i++) cycle(ra, rb);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic mid_reset(input bit ra, input bit rb);
        bus.raw_a = ra;
        bus.raw_b = rb;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_Ta",      bus.Ta,      1'b0);
        chk("rst_Tb",      bus.Tb,      1'b0);
        chk("rst_stuck_a", bus.stuck_a, 1'b0);
        chk("rst_stuck_b", bus.stuck_b, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    bit lvl[2];
    int dur[2];

    initial begin
        reset_n   = 1'b0;
        bus.raw_a = 1'b0;
        bus.raw_b = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Clean arrival then departure on A.
        run(1'b1, 1'b0, 40);
        run(1'b0, 1'b0, 15);

        // Reset mid-presence with A still high; Ta returns at edge 6 after release.
        mid_reset(1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 1'b0);
            if (i == 5) chk("arrive_e5", bus.Ta, 1'b0);
            if (i == 6) chk("arrive_e6", bus.Ta, 1'b1);
        end
        run(1'b0, 1'b0, 12);

        // B bounce shorter than debounce, then exactly the debounce length.
        run(1'b0, 1'b1, 3);
        run(1'b0, 1'b0, 12);
        run(1'b0, 1'b1, 4);
        run(1'b0, 1'b0, 14);

        // Gap shorter than hold; the presence age restarts afterwards.
        run(1'b1, 1'b0, 50);
        run(1'b0, 1'b0, 5);
        run(1'b1, 1'b0, 60);
        run(1'b0, 1'b0, 12);

        // Stuck detector on A, released; parallel stuck on B with different length.
        run(1'b1, 1'b1, 100);
        run(1'b0, 1'b1, 3);
        chk("stuck_a_clear", bus.stuck_a, 1'b0);
        chk("stuck_b_held",  bus.stuck_b, 1'b1);
        run(1'b0, 1'b0, 12);

        // Random independent waveforms, with occasional mid-run resets.
        lvl[0] = 1'b0; lvl[1] = 1'b0;
        dur[0] = 0;    dur[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < 2; l++) begin
                if (dur[l] == 0) begin
                    int r;
                    lvl[l] = ~lvl[l];
                    r = $urandom_range(0, 9);
                    if (r < 4)      dur[l] = $urandom_range(1, 5);
                    else if (r < 7) dur[l] = $urandom_range(1, 15);
                    else if (r < 9) dur[l] = $urandom_range(7, 12);
                    else            dur[l] = $urandom_range(60, 90);
                end
                dur[l]--;
            end
            if (c == 900 || c == 2100) mid_reset(lvl[0], lvl[1]);
            else                       cycle(lvl[0], lvl[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
